dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the data memory block (MemRead/MemWrite/a/wd/Funct3/rd interface). It shares the memory between the CPU load/store unit (port 0) and a debug/DMA loader (port 1) using round-robin arbitration. Each accepted request is registered, issued to memory for exactly one cycle, and answered on the requester's response channel. Misaligned and unsupported accesses are rejected with an error response and never reach memory.

Parameters:
DM_ADDRESS, 9, memory byte-address width
DATA_W, 32, data width
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
p0_req_valid  in  1  port 0 request valid
p0_req_ready  out  1  port 0 request accepted this cycle
p0_req_we  in  1  1=store, 0=load
p0_req_addr  in  DM_ADDRESS  byte address
p0_req_wdata  in  DATA_W  store data (LSB-aligned for SB/SH)
p0_req_funct3  in  3  RISC-V funct3 size code
p0_rsp_valid  out  1  port 0 response valid
p0_rsp_ready  in  1  port 0 response consumed
p0_rsp_rdata  out  DATA_W  load data (0 for stores/errors)
p0_rsp_err  out  1  access rejected
p1_*  same set as p0_* for port 1
MemRead  out  1  to data memory
MemWrite  out  1  to data memory
a  out  DM_ADDRESS  to data memory
wd  out  DATA_W  to data memory
Funct3  out  3  to data memory
rd  in  DATA_W  from data memory
err_cnt  out  ERR_CNT_W  saturating count of rejected requests

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all ready/rsp_valid/rsp_err=0; rsp_rdata=0; MemRead=MemWrite=0; a, wd, Funct3=0; err_cnt=0; last_grant=1 (port 0 wins first tie). Reset mid-transaction drops strobes immediately and discards the transaction with no response.
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant one port. If only one is valid, grant it. If both are valid, grant the port != last_grant.
  - Assert the granted port's req_ready combinationally that cycle only. Latch we/addr/wdata/funct3/port id; update last_grant; go to ISSUE.
  - The ungranted port sees req_ready=0 and must hold its request stable.
- Legality check, on latched fields:
  - Loads legal: funct3 000, 010, 100.
  - Stores legal: 000, 001, 010.
  - Misaligned: funct3 010 with addr[1:0]!=0; store 001 with addr[0]!=0.
  - Any illegal or misaligned request sets bad=1.
- ISSUE (exactly 1 cycle):
  - If !bad: MemRead=!we, MemWrite=we, a=addr, wd=wdata, Funct3=funct3. Capture rd into the response register at the end of the cycle when loading.
  - If bad: strobes stay 0, response data=0, err=1, err_cnt+=1 saturating at all-ones.
  - Go to RESP.
- Outside ISSUE: MemRead=MemWrite=0. a/wd/Funct3 hold their last value (no spurious strobes).
- RESP:
  - Granted port's rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1 is sampled.
  - Store responses: rdata=0, err=0 unless bad.
  - On handshake, go to IDLE. The other port's rsp_valid stays 0.
- Latency: accept at edge T; memory strobe during T+1; rsp_valid from T+2. Minimum 3 cycles per transaction. req_ready is never high outside IDLE.
- rsp_valid never high for both ports simultaneously.

Test Plan:
- Port 0 SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> MemWrite high exactly one cycle with Funct3=010; load response rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
- Both ports request in the same cycle for 4 consecutive transactions -> grants alternate 0,1,0,1 starting with port 0; no port starves.
- Port 1 LW addr 0x013 and SH addr 0x005 -> no MemRead/MemWrite pulses; rsp_err=1, rdata=0; err_cnt increments 0->2.
- Port 0 SB 0x0A5 to addr 0x101, then LB and LBU 0x101 -> rdata 0xFFFFFFA5 and 0x000000A5 respectively.
- rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, no new grants, port 1 req_ready stays 0; on rsp_ready=1, FSM returns to IDLE.
- Assert rst_n=0 during ISSUE of a store -> MemWrite drops immediately, no response issued, err_cnt=0; first request after reset grants port 0 on a tie.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// One requester channel into the data-memory arbiter: a request handshake
// carrying a single load/store and a response handshake carrying its result.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the data memory: one transaction at
// a time, one-cycle memory issue, illegal/misaligned accesses answered with an error.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         p0,
    dmem_arbiter_if.slave         p1,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd,
    output logic [ERR_CNT_W-1:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_grant;
    logic                  grant_vld;
    logic                  grant_id;
    logic                  rsp_done;

    logic                  sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [2:0]            sel_funct3;

    logic                  port_p0;
    logic                  we_p0;
    logic [DM_ADDRESS-1:0] addr_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic [2:0]            f3_p0;
    logic                  bad_p0;
    logic                  issue_ok;

    logic [DM_ADDRESS-1:0] a_hold;
    logic [DATA_W-1:0]     wd_hold;
    logic [2:0]            f3_hold;

    logic [DATA_W-1:0]     rdata_p1;
    logic                  err_p1;
    logic [ERR_CNT_W-1:0]  err_cnt_q;

    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lsb);
        logic supported;
        logic misaligned;
        if (we) supported = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    supported = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100);
        misaligned = ((f3 == 3'b010) && (lsb != 2'b00)) ||
                     (we && (f3 == 3'b001) && lsb[0]);
        return !supported || misaligned;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign rsp_done = port_p0 ? p1.rsp_ready : p0.rsp_ready;

    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0.req_valid || p1.req_valid) begin
                    grant_vld = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    if (p0.req_valid && p1.req_valid) grant_id = ~last_grant;
                    else                              grant_id = p1.req_valid;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign p0.req_ready = grant_vld && !grant_id;
    assign p1.req_ready = grant_vld &&  grant_id;

    assign sel_we     = grant_id ? p1.req_we     : p0.req_we;
    assign sel_addr   = grant_id ? p1.req_addr   : p0.req_addr;
    assign sel_wdata  = grant_id ? p1.req_wdata  : p0.req_wdata;
    assign sel_funct3 = grant_id ? p1.req_funct3 : p0.req_funct3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            port_p0    <= 1'b0;
            we_p0      <= 1'b0;
            addr_p0    <= '0;
            wdata_p0   <= '0;
            f3_p0      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                last_grant <= grant_id;
                port_p0    <= grant_id;
                we_p0      <= sel_we;
                addr_p0    <= sel_addr;
                wdata_p0   <= sel_wdata;
                f3_p0      <= sel_funct3;
            end
        end
    end

    // Stage p0 -> memory: the latched request drives the bus for the single ISSUE cycle.
    assign bad_p0   = req_illegal(we_p0, f3_p0, addr_p0[1:0]);
    assign issue_ok = (state_q == ISSUE) && !bad_p0;

    assign MemRead  = issue_ok && !we_p0;
    assign MemWrite = issue_ok &&  we_p0;
    assign a        = issue_ok ? addr_p0  : a_hold;
    assign wd       = issue_ok ? wdata_p0 : wd_hold;
    assign Funct3   = issue_ok ? f3_p0    : f3_hold;

    // Stage p1: response captured at the end of ISSUE, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold    <= '0;
            wd_hold   <= '0;
            f3_hold   <= '0;
            rdata_p1  <= '0;
            err_p1    <= 1'b0;
            err_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            rdata_p1 <= (bad_p0 || we_p0) ? '0 : rd;
            err_p1   <= bad_p0;
            if (bad_p0) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end else begin
                a_hold  <= addr_p0;
                wd_hold <= wdata_p0;
                f3_hold <= f3_p0;
            end
        end
    end

    assign p0.rsp_valid = (state_q == RESP) && !port_p0;
    assign p1.rsp_valid = (state_q == RESP) &&  port_p0;
    assign p0.rsp_rdata = p0.rsp_valid ? rdata_p1 : '0;
    assign p1.rsp_rdata = p1.rsp_valid ? rdata_p1 : '0;
    assign p0.rsp_err   = p0.rsp_valid && err_p1;
    assign p1.rsp_err   = p1.rsp_valid && err_p1;

    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array data memory, transaction-level reference
// model checked every cycle, directed scenarios plus randomized two-port traffic.
module tb_dmem_arbiter;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int ECW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]    rv, rwe, rrdy;
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rwd   [2];
    logic [2:0]    rf3   [2];
    logic [1:0]    ordy, ovld, oerr;
    logic [DW-1:0] ordata [2];

    logic          MemRead, MemWrite;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [2:0]    Funct3;
    logic [ECW-1:0] err_cnt;

    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) i0 ();
    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) i1 ();

    assign i0.req_valid = rv[0];   assign i1.req_valid = rv[1];
    assign i0.req_we    = rwe[0];  assign i1.req_we    = rwe[1];
    assign i0.req_addr  = raddr[0]; assign i1.req_addr = raddr[1];
    assign i0.req_wdata = rwd[0];  assign i1.req_wdata = rwd[1];
    assign i0.req_funct3 = rf3[0]; assign i1.req_funct3 = rf3[1];
    assign i0.rsp_ready = rrdy[0]; assign i1.rsp_ready = rrdy[1];
    assign ordy   = {i1.req_ready, i0.req_ready};
    assign ovld   = {i1.rsp_valid, i0.rsp_valid};
    assign oerr   = {i1.rsp_err,   i0.rsp_err};
    assign ordata[0] = i0.rsp_rdata;
    assign ordata[1] = i1.rsp_rdata;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .rst_n(rst_n), .p0(i0), .p1(i1),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd),
        .Funct3(Funct3), .rd(rd), .err_cnt(err_cnt)
    );

    // Data memory seen by the DUT: little-endian bytes, sign/zero extension by Funct3.
    bit [7:0] mem [512];
    always @(posedge clk) begin
        if (MemWrite) begin
            mem[a] <= wd[7:0];
            if (Funct3 != 3'b000) mem[a + 9'd1] <= wd[15:8];
            if (Funct3 == 3'b010) begin
                mem[a + 9'd2] <= wd[23:16];
                mem[a + 9'd3] <= wd[31:24];
            end
        end
    end
    always_comb begin
        rd = 32'h5A5A_A5A5;
        if (MemRead) begin
            case (Funct3)
                3'b000:  rd = {{24{mem[a][7]}}, mem[a]};
                3'b100:  rd = {24'd0, mem[a]};
                3'b010:  rd = {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
                default: rd = 32'hDEAD_0000;
            endcase
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by its size/alignment rules.
    bit [7:0] ref_mem [512];
    bit          busy, mlast, mport, mwe, mbad;
    int          k;
    logic [AW-1:0] maddr, ha;
    logic [DW-1:0] mwd, mexp, hwd;
    logic [2:0]  mf3, hf3;
    logic [ECW-1:0] mcnt;
    int          err_total = 0;
    int          mw_n = 0, mr_n = 0;
    logic [2:0]  mw_f3;
    bit          eg_vld;
    int          eg;

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001:         return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit model_bad(input bit we, input logic [2:0] f3, input logic [AW-1:0] ad);
        bit ok;
        ok = we ? (f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b000, 3'b010, 3'b100});
        if (!ok) return 1'b1;
        return (int'(ad) % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [AW-1:0] ad, input logic [2:0] f3);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < acc_size(f3); i++) w = w | (32'(ref_mem[9'(int'(ad) + i)]) << (8 * i));
        if (f3 == 3'b000) w = {{24{w[7]}}, w[7:0]};
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(ordy), 0);
            chk("rst_rsp_valid", 32'(ovld), 0);
            chk("rst_rsp_err", 32'(oerr), 0);
            chk("rst_rdata0", ordata[0], 0);
            chk("rst_rdata1", ordata[1], 0);
            chk("rst_strobes", 32'({MemRead, MemWrite}), 0);
            chk("rst_a", 32'(a), 0);
            chk("rst_wd", wd, 0);
            chk("rst_funct3", 32'(Funct3), 0);
            chk("rst_err_cnt", 32'(err_cnt), 0);
            busy = 0; k = 0; mlast = 1'b1; mcnt = '0;
            ha = '0; hwd = '0; hf3 = '0;
        end else begin
            if (MemWrite) begin mw_n++; mw_f3 = Funct3; end
            if (MemRead) mr_n++;
            chk("err_cnt", 32'(err_cnt), 32'(mcnt));
            if (!(busy && k == 1)) begin
                chk("idle_strobes", 32'({MemRead, MemWrite}), 0);
                chk("hold_a", 32'(a), 32'(ha));
                chk("hold_wd", wd, hwd);
                chk("hold_funct3", 32'(Funct3), 32'(hf3));
            end
            if (!busy) begin
                eg_vld = (rv != 2'b00);
                eg = (rv == 2'b11) ? (mlast ? 0 : 1) : (rv[1] ? 1 : 0);
                chk("idle_req_ready", 32'(ordy), eg_vld ? (32'd1 << eg) : 32'd0);
                chk("idle_rsp_valid", 32'(ovld), 0);
                if (eg_vld) begin
                    busy = 1; k = 1; mport = eg[0]; mlast = eg[0];
                    mwe = rwe[eg]; maddr = raddr[eg]; mwd = rwd[eg]; mf3 = rf3[eg];
                    mbad = model_bad(mwe, mf3, maddr);
                end
            end else if (k == 1) begin
                chk("issue_req_ready", 32'(ordy), 0);
                chk("issue_rsp_valid", 32'(ovld), 0);
                chk("issue_memread", 32'(MemRead), 32'(!mbad && !mwe));
                chk("issue_memwrite", 32'(MemWrite), 32'(!mbad && mwe));
                if (!mbad) begin
                    chk("issue_a", 32'(a), 32'(maddr));
                    chk("issue_wd", wd, mwd);
                    chk("issue_funct3", 32'(Funct3), 32'(mf3));
                    ha = maddr; hwd = mwd; hf3 = mf3;
                end
                if (mbad) begin
                    err_total++;
                    if (mcnt != '1) mcnt = mcnt + ECW'(1);
                    mexp = '0;
                end else if (mwe) begin
                    for (int i = 0; i < acc_size(mf3); i++) ref_mem[9'(int'(maddr) + i)] = mwd[8*i +: 8];
                    mexp = '0;
                end else begin
                    mexp = ref_load(maddr, mf3);
                end
                k = 2;
            end else begin
                chk("rsp_req_ready", 32'(ordy), 0);
                chk("rsp_valid", 32'(ovld), mport ? 32'd2 : 32'd1);
                chk("rsp_rdata", ordata[mport], mexp);
                chk("rsp_err", 32'(oerr[mport]), 32'(mbad));
                if (rrdy[mport]) busy = 0;
            end
        end
    end

    task automatic do_req(input int p, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                          input logic [2:0] f3, output logic [DW-1:0] rdata, output logic err,
                          output int lat);
        int n;
        rv[p] = 1'b1; rwe[p] = we; raddr[p] = ad; rwd[p] = d; rf3[p] = f3; rrdy[p] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ordy[p] && n < 50);
        chk("accept_seen", 32'(ordy[p]), 1);
        @(posedge clk); #1 rv[p] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ovld[p] && lat < 50);
        rdata = ordata[p]; err = oerr[p];
        @(posedge clk); #1;
    endtask

    task automatic rand_port(input int p, input int n);
        int c;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            rwe[p] = 1'($urandom_range(0, 1));
            raddr[p] = AW'($urandom);
            if ($urandom_range(0, 3) != 0) raddr[p][1:0] = 2'b00;
            rwd[p] = $urandom;
            rf3[p] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) rf3[p] = rwe[p] ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 1) * 2);
            rv[p] = 1'b1;
            c = 0;
            do begin @(negedge clk); c++; end while (!ordy[p] && c < 200);
            if (!ordy[p]) chk("rand_accept_timeout", 32'(ordy[p]), 1);
            @(posedge clk); #1 rv[p] = 1'b0;
        end
    endtask

    logic [DW-1:0] rdt, d0;
    logic          er;
    int            lat, n, ng, mw0, mr0;
    int            gq [4];
    bit            rnd_on;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rv = '0; rwe = '0; rrdy = '0;
        for (int i = 0; i < 2; i++) begin raddr[i] = '0; rwd[i] = '0; rf3[i] = '0; end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_err_cnt", 32'(err_cnt), 0);

        // Simultaneous requests: grants alternate starting with port 0.
        @(posedge clk); #1;
        rwe = 2'b00; raddr[0] = 9'h020; raddr[1] = 9'h040; rf3[0] = 3'b010; rf3[1] = 3'b010;
        rrdy = 2'b11; rv = 2'b11;
        ng = 0; n = 0;
        while (ng < 4 && n < 100) begin
            @(negedge clk); n++;
            if (ordy != 2'b00) begin gq[ng] = ordy[1] ? 1 : 0; ng++; end
        end
        @(posedge clk); #1 rv = 2'b00;
        chk("tie_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) chk("tie_grant_order", gq[i], i % 2);
        repeat (4) @(posedge clk); #1;

        // SW then LW at 0x010.
        mw0 = mw_n;
        do_req(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rdt, er, lat);
        chk("sw_memwrite_pulses", mw_n - mw0, 1);
        chk("sw_funct3", 32'(mw_f3), 32'h2);
        chk("sw_err", 32'(er), 0);
        chk("sw_rdata", rdt, 0);
        do_req(0, 1'b0, 9'h010, 32'h0, 3'b010, rdt, er, lat);
        chk("lw_rdata", rdt, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 0);
        chk("lw_latency", lat, 2);

        // Misaligned accesses on port 1 never reach memory.
        mw0 = mw_n; mr0 = mr_n;
        do_req(1, 1'b0, 9'h013, 32'h0, 3'b010, rdt, er, lat);
        chk("lw_mis_err", 32'(er), 1);
        chk("lw_mis_rdata", rdt, 0);
        do_req(1, 1'b1, 9'h005, 32'h1234, 3'b001, rdt, er, lat);
        chk("sh_mis_err", 32'(er), 1);
        chk("sh_mis_rdata", rdt, 0);
        chk("mis_no_strobes", (mw_n - mw0) + (mr_n - mr0), 0);
        chk("mis_err_cnt", 32'(err_cnt), 2);

        // Byte store and sign/zero-extending byte loads.
        do_req(0, 1'b1, 9'h101, 32'h000000A5, 3'b000, rdt, er, lat);
        do_req(0, 1'b0, 9'h101, 32'h0, 3'b000, rdt, er, lat);
        chk("lb_rdata", rdt, 32'hFFFFFFA5);
        do_req(0, 1'b0, 9'h101, 32'h0, 3'b100, rdt, er, lat);
        chk("lbu_rdata", rdt, 32'h000000A5);

        // Response back-pressure while port 1 waits.
        rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 9'h010; rf3[0] = 3'b010; rrdy = 2'b00;
        n = 0;
        do begin @(negedge clk); n++; end while (!ordy[0] && n < 50);
        @(posedge clk); #1 rv[0] = 1'b0;
        rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 9'h100; rf3[1] = 3'b010;
        n = 0;
        do begin @(negedge clk); n++; end while (!ovld[0] && n < 50);
        d0 = ordata[0];
        chk("stall_first_rdata", d0, 32'hDEADBEEF);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(ovld[0]), 1);
            chk("stall_rdata", ordata[0], d0);
            chk("stall_p1_ready", 32'(ordy[1]), 0);
        end
        @(posedge clk); #1 rrdy = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!ordy[1] && n < 50);
        chk("stall_p1_granted_after", n, 2);
        @(posedge clk); #1 rv[1] = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Randomized two-port traffic with random response back-pressure.
        rnd_on = 1'b1;
        fork
            begin
                fork
                    rand_port(0, 150);
                    rand_port(1, 150);
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin @(posedge clk); #1 rrdy = 2'($urandom); end
            end
        join
        rrdy = 2'b11;
        repeat (6) @(posedge clk); #1;
        if (err_total >= 15) chk("err_cnt_saturated", 32'(err_cnt), 32'hF);

        // Reset during the ISSUE cycle of a store.
        rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 9'h020; rwd[0] = 32'h11223344; rf3[0] = 3'b010;
        n = 0;
        do begin @(negedge clk); n++; end while (!ordy[0] && n < 50);
        @(posedge clk); #2;
        chk("issue_store_memwrite", 32'(MemWrite), 1);
        rst_n = 1'b0; rv = 2'b00;
        #1;
        chk("rst_drops_memwrite", 32'(MemWrite), 0);
        chk("rst_no_response", 32'(ovld), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("rst_err_cnt_cleared", 32'(err_cnt), 0);
        @(posedge clk); #1;
        rwe = 2'b00; raddr[0] = 9'h040; raddr[1] = 9'h080; rf3[0] = 3'b010; rf3[1] = 3'b010; rv = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (ordy == 2'b00 && n < 50);
        chk("post_reset_tie_grant", 32'(ordy), 1);
        @(posedge clk); #1 rv = 2'b00;
        repeat (5) @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
